// File: rtl/paralelo_serial_pcie_pkg.sv
// rtl/paralelo_serial_pcie_pkg.sv - shared symbol constants and link state encoding for the pcie serial path
package paralelo_serial_pcie_pkg;

    localparam logic [7:0] K28_5_SYM = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } link_state_t;

endpackage

// File: rtl/paralelo_serial_pcie_if.sv
// rtl/paralelo_serial_pcie_if.sv - parallel byte stream from the pcie data path into the serializer
interface paralelo_serial_pcie_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] DATA_IN;
    logic              VALID_IN;
    logic              READY_OUT;

    modport master (output DATA_IN, output VALID_IN, input READY_OUT);
    modport slave  (input DATA_IN, input VALID_IN, output READY_OUT);
endinterface

// File: rtl/fifo_sync_pcie.sv
// rtl/fifo_sync_pcie.sv - small synchronous FIFO shared by the pcie transmit and receive sides
module fifo_sync_pcie #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/paralelo_serial_pcie.sv
// rtl/paralelo_serial_pcie.sv - buffered MSB-first serializer with idle fill and post-reset sync preamble
module paralelo_serial_pcie
    import paralelo_serial_pcie_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(K28_5_SYM),
    parameter int               FIFO_DEPTH = 4,
    parameter int               SYNC_SYMS  = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    paralelo_serial_pcie_if.slave bus,
    output logic                  SERIAL_OUT,
    output logic                  SYM_START,
    output logic                  SYM_VALID,
    output logic                  LINK_UP,
    output logic                  OVERFLOW
);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SYNC_W = $clog2(SYNC_SYMS + 1);

    link_state_t       state_q, state_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] sym;
    logic              full, empty;
    logic              load, push, drop, pop;

    assign load          = (bit_cnt == BIT_W'(DATA_W - 1));
    assign push          = bus.VALID_IN && !full;
    assign drop          = bus.VALID_IN && full;
    assign pop           = load && (state_q == RUN) && !empty;
    assign sym           = pop ? head : IDLE_SYM;
    assign bus.READY_OUT = !full;

    fifo_sync_pcie #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .wdata (bus.DATA_IN),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count ()
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    // The last preamble symbol is still idle; RUN only affects the following load.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        if (load && state_q == SYNC) begin
            sync_cnt_d = sync_cnt_q + 1'b1;
            if (sync_cnt_q == SYNC_W'(SYNC_SYMS - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            SERIAL_OUT <= 1'b0;
            SYM_START  <= 1'b0;
            SYM_VALID  <= 1'b0;
            LINK_UP    <= 1'b0;
            OVERFLOW   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= BIT_W'(DATA_W - 1);
        end else begin
            LINK_UP <= (state_d == RUN);
            if (drop) begin
                OVERFLOW <= 1'b1;
            end
            if (load) begin
                SERIAL_OUT <= sym[DATA_W-1];
                shreg      <= sym << 1;
                SYM_START  <= 1'b1;
                SYM_VALID  <= pop;
                bit_cnt    <= '0;
            end else begin
                SERIAL_OUT <= shreg[DATA_W-1];
                shreg      <= shreg << 1;
                SYM_START  <= 1'b0;
                bit_cnt    <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_paralelo_serial_pcie.sv
// tb/tb_paralelo_serial_pcie.sv - scoreboard bench for the pcie serializer
module tb_paralelo_serial_pcie;
    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic SERIAL_OUT, SYM_START, SYM_VALID, LINK_UP, OVERFLOW;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];

    paralelo_serial_pcie_if #(.DATA_W(8)) bus ();

    paralelo_serial_pcie dut (
        .CLK        (CLK),
        .reset      (reset),
        .bus        (bus.slave),
        .SERIAL_OUT (SERIAL_OUT),
        .SYM_START  (SYM_START),
        .SYM_VALID  (SYM_VALID),
        .LINK_UP    (LINK_UP),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reassemble each symbol and compare against the scoreboard.
    logic [7:0] mon_sym;
    int         mon_nb;
    logic       mon_on = 1'b0;
    logic       mon_sv;
    logic       mon_sv_bad;
    logic [7:0] mon_exp;

    always @(negedge CLK) begin
        if (!reset) begin
            mon_on = 1'b0;
        end else begin
            if (SYM_START) begin
                mon_on     = 1'b1;
                mon_nb     = 0;
                mon_sym    = '0;
                mon_sv     = SYM_VALID;
                mon_sv_bad = 1'b0;
            end
            if (mon_on) begin
                mon_sym = {mon_sym[6:0], SERIAL_OUT};
                if (SYM_VALID !== mon_sv) mon_sv_bad = 1'b1;
                mon_nb++;
                if (mon_nb == 8) begin
                    mon_on = 1'b0;
                    check("sym_valid_steady", mon_sv_bad, 1'b0);
                    if (mon_sv) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_data_sym", mon_sym, 64'hFFFF);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            check("data_sym", mon_sym, mon_exp);
                        end
                    end else begin
                        check("idle_sym", mon_sym, 8'hBC);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_load();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!SYM_START && n < 20);
        check("load_seen", SYM_START, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        wait_load();
        wait_load();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_serial"}, SERIAL_OUT, 1'b0);
        check({tag, "_start"}, SYM_START, 1'b0);
        check({tag, "_valid"}, SYM_VALID, 1'b0);
        check({tag, "_link"}, LINK_UP, 1'b0);
        check({tag, "_overflow"}, OVERFLOW, 1'b0);
        check({tag, "_ready"}, bus.READY_OUT, 1'b1);
    endtask

    // Releases reset away from an edge and checks the 33 edges that follow.
    task automatic release_and_check_sync(input string tag);
        logic [32:0] ser, st, lk, vd;
        logic [32:0] e_ser, e_st, e_lk;
        logic [7:0]  idle = 8'hBC;
        @(negedge CLK);
        reset = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            tick();
            ser[e-1]   = SERIAL_OUT;
            st[e-1]    = SYM_START;
            lk[e-1]    = LINK_UP;
            vd[e-1]    = SYM_VALID;
            e_ser[e-1] = idle[7 - ((e - 1) % 8)];
            e_st[e-1]  = ((e - 1) % 8 == 0);
            e_lk[e-1]  = (e >= 25);
        end
        check({tag, "_sync_serial"}, ser, e_ser);
        check({tag, "_sync_start"}, st, e_st);
        check({tag, "_sync_link"}, lk, e_lk);
        check({tag, "_sync_valid"}, vd, 33'h0);
    endtask

    initial begin
        bus.DATA_IN  = '0;
        bus.VALID_IN = 1'b0;

        for (int i = 0; i < 3; i++) begin
            bus.DATA_IN  = 8'($urandom);
            bus.VALID_IN = 1'($urandom);
            tick();
        end
        check_reset_outputs("reset");
        bus.VALID_IN = 1'b0;

        release_and_check_sync("first");

        // Single byte pushed mid-symbol.
        wait_load();
        tick();
        tick();
        bus.DATA_IN  = 8'hA5;
        bus.VALID_IN = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        bus.VALID_IN = 1'b0;
        drain();

        // Five-byte burst into a four-entry FIFO.
        wait_load();
        for (int i = 1; i <= 5; i++) begin
            bus.DATA_IN  = 8'(i);
            bus.VALID_IN = 1'b1;
            if (i <= 4) exp_q.push_back(8'(i));
            tick();
            if (i == 3) check("ready_before_full", bus.READY_OUT, 1'b1);
            if (i == 4) check("ready_when_full", bus.READY_OUT, 1'b0);
        end
        bus.VALID_IN = 1'b0;
        check("overflow_set", OVERFLOW, 1'b1);
        drain();
        check("overflow_sticky", OVERFLOW, 1'b1);

        // Push exactly on the load edge: no bypass.
        wait_load();
        for (int i = 0; i < 7; i++) tick();
        bus.DATA_IN  = 8'h3C;
        bus.VALID_IN = 1'b1;
        exp_q.push_back(8'h3C);
        tick();
        bus.VALID_IN = 1'b0;
        check("load_push_start", SYM_START, 1'b1);
        check("load_push_not_bypassed", SYM_VALID, 1'b0);
        drain();

        // Reset in the middle of a data symbol with two bytes still queued.
        wait_load();
        bus.VALID_IN = 1'b1;
        bus.DATA_IN  = 8'h55;
        tick();
        bus.DATA_IN  = 8'h11;
        tick();
        bus.DATA_IN  = 8'h22;
        tick();
        bus.VALID_IN = 1'b0;
        wait_load();
        check("mid_sym_valid", SYM_VALID, 1'b1);
        check("mid_sym_msb", SERIAL_OUT, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        release_and_check_sync("second");

        for (int i = 0; i < 3; i++) wait_load();
        check("post_reset_idle", SYM_VALID, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/paralelo_serial_pcie.md
Name: paralelo_serial_pcie

Overview:
- Transmit serializer directly downstream of the pcie data path.
- Consumes the byte stream on DATA/VALID_OUT, buffers short bursts in a small FIFO, and shifts each symbol out MSB-first, one bit per CLK.
- Inserts idle/comma symbols (IDLE_SYM) whenever no data is queued, and runs a fixed sync preamble after reset before raising LINK_UP.

Parameters:
- DATA_W, 8, symbol width in bits; bit counter width is clog2(DATA_W).
- IDLE_SYM, 8'hBC, symbol sent when the FIFO is empty and during sync.
- FIFO_DEPTH, 4, input buffer entries; must be a power of two, at least 2.
- SYNC_SYMS, 4, number of IDLE_SYM symbols sent after reset before RUN.

Ports:
- CLK  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- DATA_IN  input  DATA_W  byte from the pcie block's DATA output.
- VALID_IN  input  1  DATA_IN qualifier, driven by the pcie block's VALID_OUT.
- READY_OUT  output  1  high when the FIFO is not full (informational; the upstream block does not stall).
- SERIAL_OUT  output  1  serial bit stream, MSB first.
- SYM_START  output  1  high during the first (MSB) bit of every symbol.
- SYM_VALID  output  1  high for all DATA_W bits of a data symbol; low for idle symbols.
- LINK_UP  output  1  high while in RUN.
- OVERFLOW  output  1  sticky; set when a valid byte is dropped.

Behaviour:
- Reset (reset=0, asynchronous): SERIAL_OUT=0, SYM_START=0, SYM_VALID=0, LINK_UP=0, OVERFLOW=0, READY_OUT=1 (FIFO empty), FIFO pointers and count=0, bit_cnt=DATA_W-1, sync_cnt=0, state=SYNC. Any symbol in flight is abandoned.
- All outputs are registered except READY_OUT, which is combinational: READY_OUT = !full.
- Push: on an edge with VALID_IN=1 and full=0 (pre-edge value), DATA_IN is written.
- Drop: VALID_IN=1 with full=1 drops the byte and sets OVERFLOW. This holds even if a pop happens on the same edge; there is no pass-through on full.
- Load edge (bit_cnt==DATA_W-1):
  - Select sym: in SYNC, sym=IDLE_SYM. In RUN, if the FIFO is non-empty (pre-edge), pop the head and sym=head with SYM_VALID<=1; otherwise sym=IDLE_SYM with SYM_VALID<=0.
  - Update: SERIAL_OUT<=sym[DATA_W-1], shreg<=sym<<1, SYM_START<=1, bit_cnt<=0.
- Other edges: SERIAL_OUT<=shreg[MSB], shreg<=shreg<<1, SYM_START<=0, bit_cnt<=bit_cnt+1. SYM_VALID holds its value.
- Simultaneous push and pop: both occur and count is unchanged. A byte pushed on a load edge into an empty FIFO is not bypassed; it goes out on the next symbol.
- Latency: the first edge after reset release is a load edge. Minimum byte-to-first-bit latency is 1 edge, maximum is DATA_W×(count+1) edges.
- State machine:
  - SYNC: each load edge increments sync_cnt. On the load edge where sync_cnt==SYNC_SYMS-1, go to RUN and set LINK_UP<=1 on that edge. That symbol is still IDLE_SYM; the next load edge is the first RUN symbol.
  - RUN: terminal until reset.
- FIFO behaviour during SYNC: pushes are accepted, but nothing is popped.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH. bit_cnt wraps DATA_W-1→0 only through a load.
- Clearing OVERFLOW: only reset clears it.

Decomposition:
- Shared package holds IDLE_SYM (K28.5 8'hBC) and the state encoding (SYNC=1'b0, RUN=1'b1), also used by the matching receiver.
- One natural sub-module: fifo_sync_pcie, a parameterized DATA_W×FIFO_DEPTH synchronous FIFO with push/pop/full/empty/count and the same CLK/reset. It is reused by the receive side.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with random DATA_IN/VALID_IN → all outputs at reset values; READY_OUT=1.
- Sync preamble: release reset, VALID_IN=0 → 4 symbols of 1,0,1,1,1,1,0,0 (0xBC), SYM_START on edges 1,9,17,25, SYM_VALID=0, LINK_UP rises on edge 25, and edge 33 starts another 0xBC.
- Single byte: in RUN, push 0xA5 mid-symbol → next symbol is 1,0,1,0,0,1,0,1 with SYM_VALID=1 for 8 cycles, then 0xBC with SYM_VALID=0.
- Burst overflow: on the 5 edges after a load, push 0x01..0x05 → 0x01–0x04 accepted, READY_OUT=0 after the 4th, 0x05 dropped, OVERFLOW=1 (sticky). Serial then carries 01, 02, 03, 04, BC.
- Push on a load edge with an empty FIFO: push 0x3C exactly on the load edge → current symbol is 0xBC, next symbol is 0x3C.
- Reset mid-operation: assert reset at bit 3 of data symbol 0x55 with 2 bytes queued → outputs clear immediately (asynchronously), FIFO empties, and after release the 4-symbol sync sequence restarts.
